// File: rtl/mem_dma_pkg.sv
// Shared definitions for the word-copy / word-fill DMA engine.
package mem_dma_pkg;

   // Default number of words in the attached memory.
   localparam int MEM_DEPTH = 256;

   // Width of the internal word pointers.
   localparam int ADDR_W = 8;

   // Engine states. READ fetches one source word and WRITE stores one
   // destination word.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Advances a word pointer and wraps it back to 0 after the last word.
   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr,
                                                 input int depth);
      logic [ADDR_W-1:0] nxt;
      if (int'(ptr) == depth - 1) nxt = '0;
      else                        nxt = ptr + 1'b1;
      return nxt;
   endfunction

endpackage

// File: rtl/mem_dma.sv
// Single-channel DMA engine for a small word memory.
// Copy mode moves one word every two cycles (READ then WRITE). It always
// copies forward, so an overlapping destination replicates source data.
// Fill mode writes fill_value once per cycle.
module mem_dma
   import mem_dma_pkg::*;
#(
   parameter int MEM_DEPTH = mem_dma_pkg::MEM_DEPTH,
   parameter int LEN_W     = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [15:0]      src_addr,
   input  logic [15:0]      dst_addr,
   input  logic [LEN_W-1:0] length,
   input  logic [15:0]      fill_value,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] words_done,
   output logic             mem_we,
   output logic [15:0]      mem_address,
   output logic [15:0]      mem_data_in,
   input  logic [15:0]      mem_data_out
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MEM_DEPTH);

   state_t            state_reg,   state_next;
   logic              mode_reg,    mode_next;
   logic [ADDR_W-1:0] src_ptr_reg, src_ptr_next;
   logic [ADDR_W-1:0] dst_ptr_reg, dst_ptr_next;
   logic [LEN_W-1:0]  len_reg,     len_next;
   logic [LEN_W-1:0]  cnt_reg,     cnt_next;
   logic [15:0]       data_reg,    data_next;
   logic [15:0]       fill_reg,    fill_next;

   logic [LEN_W-1:0]  len_sat;
   logic [LEN_W-1:0]  cnt_inc;

   assign len_sat    = (length > LEN_MAX) ? LEN_MAX : length;
   assign cnt_inc    = cnt_reg + 1'b1;
   assign words_done = cnt_reg;

   // State and transfer context registers. Reset clears everything at once, so a transfer is aborted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         mode_reg    <= 1'b0;
         src_ptr_reg <= '0;
         dst_ptr_reg <= '0;
         len_reg     <= '0;
         cnt_reg     <= '0;
         data_reg    <= '0;
         fill_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         mode_reg    <= mode_next;
         src_ptr_reg <= src_ptr_next;
         dst_ptr_reg <= dst_ptr_next;
         len_reg     <= len_next;
         cnt_reg     <= cnt_next;
         data_reg    <= data_next;
         fill_reg    <= fill_next;
      end
   end

   // Next-state logic and state-decoded memory interface outputs.
   always_comb begin
      state_next   = state_reg;
      mode_next    = mode_reg;
      src_ptr_next = src_ptr_reg;
      dst_ptr_next = dst_ptr_reg;
      len_next     = len_reg;
      cnt_next     = cnt_reg;
      data_next    = data_reg;
      fill_next    = fill_reg;
      busy         = 1'b1;
      done         = 1'b0;
      mem_we       = 1'b0;
      mem_address  = '0;
      mem_data_in  = '0;

      unique case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               mode_next    = mode;
               src_ptr_next = src_addr[ADDR_W-1:0];
               dst_ptr_next = dst_addr[ADDR_W-1:0];
               len_next     = len_sat;
               fill_next    = fill_value;
               cnt_next     = '0;
               if (len_sat == '0) state_next = DONE;
               else if (mode)     state_next = WRITE;
               else               state_next = READ;
            end
         end
         READ: begin
            mem_address = {{(16-ADDR_W){1'b0}}, src_ptr_reg};
            data_next   = mem_data_out;
            state_next  = WRITE;
         end
         WRITE: begin
            mem_we       = 1'b1;
            mem_address  = {{(16-ADDR_W){1'b0}}, dst_ptr_reg};
            mem_data_in  = mode_reg ? fill_reg : data_reg;
            src_ptr_next = ptr_inc(src_ptr_reg, MEM_DEPTH);
            dst_ptr_next = ptr_inc(dst_ptr_reg, MEM_DEPTH);
            cnt_next     = cnt_inc;
            if (cnt_inc == len_reg) state_next = DONE;
            else if (mode_reg)      state_next = WRITE;
            else                    state_next = READ;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_dma.sv
// Randomised and directed bench for mem_dma.
// It uses a word-level reference memory and checks transfer timing.
module tb_mem_dma;

   localparam int LEN_W = 9;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             mode;
   logic [15:0]      src_addr, dst_addr, fill_value;
   logic [LEN_W-1:0] length;
   logic             busy, done, mem_we;
   logic [LEN_W-1:0] words_done;
   logic [15:0]      mem_address, mem_data_in, mem_data_out;

   logic [15:0] mem     [0:255];
   logic [15:0] ref_mem [0:255];

   int n_assert = 0;
   int n_fail   = 0;

   int wr_cnt   = 0;
   int done_cnt = 0;
   int consec   = 0;
   logic prev_we = 1'b0;

   always #5 clk = ~clk;

   mem_dma dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .fill_value(fill_value), .busy(busy), .done(done),
      .words_done(words_done), .mem_we(mem_we), .mem_address(mem_address),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   assign mem_data_out = mem[mem_address[7:0]];

   // Memory model and write/done activity counters.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_address[7:0]] <= mem_data_in;
         wr_cnt <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (mem_we && prev_we) consec <= consec + 1;
      prev_we <= mem_we;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour. Words are processed strictly in order, so copies see earlier writes.
   task automatic model_xfer(input logic md, input int src, input int dst,
                             input int nwords, input logic [15:0] fv);
      for (int i = 0; i < nwords; i++)
         ref_mem[(dst + i) % 256] = md ? fv : ref_mem[(src + i) % 256];
   endtask

   task automatic cmp_mem(input string tag);
      int bad = 0;
      int first = -1;
      for (int i = 0; i < 256; i++)
         if (mem[i] !== ref_mem[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      if (bad != 0) $display("%s: first differing word at %0d: %0h vs %0h",
                             tag, first, mem[first], ref_mem[first]);
      chk(tag, bad, 0);
   endtask

   task automatic clear_counts();
      wr_cnt   = 0;
      done_cnt = 0;
      consec   = 0;
   endtask

   // Runs one transfer from IDLE and checks its timing, counters and memory image.
   // If poke is set, start is pulsed again while the transfer is busy, with other parameters.
   task automatic run_xfer(input string tag, input logic md, input int src, input int dst,
                           input int len, input logic [15:0] fv, input bit poke);
      int n, exp_cyc, cyc;
      bit seen;
      n = (len > 256) ? 256 : len;
      exp_cyc = md ? n + 1 : 2 * n + 1;
      @(negedge clk);
      clear_counts();
      start = 1'b1; mode = md; src_addr = 16'(src); dst_addr = 16'(dst);
      length = LEN_W'(len); fill_value = fv;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      seen = 1'b0;
      while (cyc < 700) begin
         if (poke && exp_cyc > 3 && cyc == 2) begin
            start = 1'b1; mode = ~md; src_addr = 16'h0033; dst_addr = 16'h0077;
            length = 9'd40; fill_value = 16'hDEAD;
         end else start = 1'b0;
         if (done) begin seen = 1'b1; break; end
         if (!busy) break;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, " done_seen"}, 32'(seen), 1);
      chk({tag, " done_cycle"}, cyc, exp_cyc);
      chk({tag, " words_done_at_done"}, 32'(words_done), n);
      @(negedge clk);
      chk({tag, " idle_after_done"}, {busy, done, mem_we}, 0);
      chk({tag, " words_done_hold"}, 32'(words_done), n);
      repeat (3) @(negedge clk);
      chk({tag, " no_queued_start"}, 32'(busy), 0);
      chk({tag, " write_count"}, wr_cnt, n);
      chk({tag, " done_pulses"}, done_cnt, 1);
      if (!md) chk({tag, " no_back_to_back_we"}, consec, 0);
      model_xfer(md, src % 256, dst % 256, n, fv);
      cmp_mem({tag, " mem_image"});
      $display("%s: mode=%0d src=%0d dst=%0d len=%0d words=%0d cycles=%0d",
               tag, md, src, dst, len, words_done, cyc);
   endtask

   initial begin
      int cyc;
      start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
      length = '0; fill_value = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      rst_n = 1'b0;
      #12;
      chk("reset outputs", {busy, done, mem_we}, 0);
      chk("reset words_done", 32'(words_done), 0);
      chk("reset mem_address", 32'(mem_address), 0);
      chk("reset mem_data_in", 32'(mem_data_in), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic copy.
      mem[10] = 16'h00A1; mem[11] = 16'h00B2; mem[12] = 16'h00C3;
      ref_mem[10] = 16'h00A1; ref_mem[11] = 16'h00B2; ref_mem[12] = 16'h00C3;
      run_xfer("copy3", 1'b0, 10, 20, 3, 16'h0000, 1'b0);
      chk("copy3 mem[22]", 32'(mem[22]), 32'h00C3);

      // Fill that wraps past the top of memory.
      run_xfer("fill_wrap", 1'b1, 250, 250, 8, 16'hFFFF, 1'b0);
      chk("fill_wrap mem[1]", 32'(mem[1]), 32'hFFFF);
      chk("fill_wrap mem[2] untouched", 32'(mem[2]), 32'(ref_mem[2]));

      // Zero length.
      run_xfer("len0", 1'b0, 7, 9, 0, 16'h1234, 1'b0);

      // Overlapping forward copy replicates the source word.
      mem[5] = 16'h0042; ref_mem[5] = 16'h0042;
      run_xfer("overlap", 1'b0, 5, 6, 4, 16'h0000, 1'b0);
      chk("overlap mem[9]", 32'(mem[9]), 32'h0042);

      // Oversized length saturates to the memory depth.
      run_xfer("len300", 1'b1, 0, 0, 300, 16'h5A5A, 1'b0);

      // Randomised transfers. Some include an ignored start pulse while busy.
      for (int t = 0; t < 10; t++) begin
         run_xfer($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 20), 16'($urandom), 1'($urandom_range(0, 1)));
      end

      // Abort: ignored start while busy, then reset during the third word write.
      @(negedge clk);
      clear_counts();
      start = 1'b1; mode = 1'b0; src_addr = 16'd100; dst_addr = 16'd150;
      length = 9'd5;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc < 6) begin
         if (cyc == 2) begin start = 1'b1; mode = 1'b1; length = 9'd9; end
         else start = 1'b0;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("abort third write active", 32'(mem_we), 1);
      rst_n = 1'b0;
      #1;
      chk("abort outputs", {busy, done, mem_we}, 0);
      chk("abort words_done", 32'(words_done), 0);
      chk("abort mem_address", 32'(mem_address), 0);
      chk("abort mem_data_in", 32'(mem_data_in), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort idle after release", {busy, done, mem_we}, 0);
      repeat (3) @(negedge clk);
      chk("abort write count", wr_cnt, 2);
      chk("abort no done", done_cnt, 0);
      model_xfer(1'b0, 100, 150, 2, 16'h0000);
      cmp_mem("abort mem_image");
      $display("abort: writes=%0d done_pulses=%0d", wr_cnt, done_cnt);

      // The engine is usable again after the abort.
      run_xfer("post_abort", 1'b1, 0, 30, 4, 16'hBEEF, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
